// File: rtl/fetch_pkg.sv
// Shared constants and buffer entry layout for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH_DEFAULT = 2;
  localparam logic [31:0] NOP_INSTR         = 32'b0;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } buf_entry_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; used for both the instruction buffer and the epoch tag queue.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             full_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Push is accepted when full only if a pop frees the slot in the same cycle.
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    pop_ok_s  = pop & (count_r != '0);
    push_ok_s = push & (!full_s | pop_ok_s);
  end

  // Pointer and occupancy update; flush empties the queue like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush && !reset) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order fetches, buffers responses, and squashes stale ones by epoch after a redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        beq_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      pc_r;
  logic [31:0]      resp_pc_r;
  logic             epoch_r;
  logic [CNT_W-1:0] buf_count_s;
  logic [CNT_W-1:0] tag_count_s;
  logic [CNT_W:0]   inflight_s;
  logic             buf_empty_s;
  logic             tag_empty_s;
  logic             tag_head_s;
  buf_entry_t       buf_head_s;
  buf_entry_t       entry_s;
  logic             issue_s;
  logic             rsp_pop_s;
  logic             rsp_keep_s;
  logic             deq_s;

  // The tag queue occupancy doubles as the outstanding-fetch count.
  always_comb begin
    inflight_s = {1'b0, tag_count_s} + {1'b0, buf_count_s};
    if (!reset && !beq_taken && (inflight_s < (CNT_W + 1)'(BUF_DEPTH))) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
    issue_s       = imem_req & imem_gnt;
    rsp_pop_s     = imem_rvalid & !tag_empty_s & !reset;
    rsp_keep_s    = rsp_pop_s & (tag_head_s == epoch_r) & !beq_taken;
    instr_valid   = !buf_empty_s & !reset;
    deq_s         = instr_valid & !stall & !beq_taken;
    entry_s.pc    = resp_pc_r;
    entry_s.instr = imem_rdata;
  end

  // resp_pc_r tracks the address of the next response that will be kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= RESET_PC;
      resp_pc_r <= RESET_PC;
      epoch_r   <= 1'b0;
    end else if (beq_taken) begin
      pc_r      <= branch_target;
      resp_pc_r <= branch_target;
      epoch_r   <= ~epoch_r;
    end else begin
      if (issue_s)    pc_r      <= pc_inc(pc_r);
      if (rsp_keep_s) resp_pc_r <= pc_inc(resp_pc_r);
    end
  end

  fetch_fifo #(.WIDTH(64), .DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk   (clk),
    .reset (reset),
    .flush (beq_taken),
    .push  (rsp_keep_s),
    .wdata (entry_s),
    .pop   (deq_s),
    .rdata (buf_head_s),
    .empty (buf_empty_s),
    .count (buf_count_s)
  );

  fetch_fifo #(.WIDTH(1), .DEPTH(BUF_DEPTH)) u_tag_queue (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .push  (issue_s),
    .wdata (epoch_r),
    .pop   (rsp_pop_s),
    .rdata (tag_head_s),
    .empty (tag_empty_s),
    .count (tag_count_s)
  );

  assign imem_addr       = pc_r;
  assign instruction_out = instr_valid ? buf_head_s.instr : NOP_INSTR;
  assign pc_out          = instr_valid ? buf_head_s.pc : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table with hand-computed outputs plus a wrap/reset scoreboard run.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset, stall, beq_taken, imem_gnt;
  logic [31:0] branch_target;
  logic        req1, rvalid1, valid1, req2, rvalid2, valid2;
  logic [31:0] addr1, rdata1, instr1, pc1, addr2, rdata2, instr2, pc2;
  logic        hold, spur;
  logic [31:0] pend1[$];
  logic [31:0] pend2[$];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        rst, stl, beq;
    logic [31:0] tgt;
    logic        hld, spr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fetch_stage dut1 (
    .clk(clk), .reset(reset), .stall(stall), .beq_taken(beq_taken), .branch_target(branch_target),
    .imem_req(req1), .imem_addr(addr1), .imem_gnt(imem_gnt), .imem_rvalid(rvalid1), .imem_rdata(rdata1),
    .instruction_out(instr1), .pc_out(pc1), .instr_valid(valid1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .beq_taken(beq_taken), .branch_target(branch_target),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .instruction_out(instr2), .pc_out(pc2), .instr_valid(valid2)
  );

  function automatic vec_t mk(input logic r, s, b, input logic [31:0] t, input logic h, sp,
                              input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.stl = s; v.beq = b; v.tgt = t; v.hld = h; v.spr = sp;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies inputs at the falling edge; the memory model presents the oldest pending response unless held.
  task automatic drive(input logic r, s, b, input logic [31:0] t, input logic h, sp);
    reset = r; stall = s; beq_taken = b; branch_target = t; hold = h; spur = sp; imem_gnt = 1'b1;
    if (sp) begin
      rvalid1 = 1'b1; rdata1 = 32'hDEAD_BEEF;
    end else if (!h && pend1.size() > 0) begin
      rvalid1 = 1'b1; rdata1 = pend1[0] ^ KEY;
    end else begin
      rvalid1 = 1'b0; rdata1 = 32'h0;
    end
    if (!h && pend2.size() > 0) begin
      rvalid2 = 1'b1; rdata2 = pend2[0] ^ KEY;
    end else begin
      rvalid2 = 1'b0; rdata2 = 32'h0;
    end
    #1;
  endtask

  task automatic advance();
    logic f1, f2, p1, p2;
    logic [31:0] a1, a2;
    f1 = req1 & imem_gnt; a1 = addr1; p1 = rvalid1 & !spur;
    f2 = req2 & imem_gnt; a2 = addr2; p2 = rvalid2;
    @(posedge clk);
    if (p1) void'(pend1.pop_front());
    if (f1) pend1.push_back(a1);
    if (p2) void'(pend2.pop_front());
    if (f2) pend2.push_back(a2);
    if (reset) begin
      pend1.delete();
      pend2.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t        v;
    int          n1, n2;
    logic [31:0] e1, e2;

    // rst stl beq tgt hold spur | req addr valid pc
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 32'h000, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h000, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h004, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h008, 1, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h008, 1, 32'h004));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h00C, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h010, 1, 32'h008));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h010, 1, 32'h00C));
    // five stall cycles: buffer fills, request drops, head frozen
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 1, 32'h014, 0, 32'h000));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h018, 1, 32'h010));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h018, 1, 32'h010));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h018, 1, 32'h010));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h018, 1, 32'h010));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h018, 1, 32'h010));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h018, 1, 32'h014));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h01C, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h020, 1, 32'h018));
    // two fetches left outstanding, then redirect to 0x100
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h020, 1, 32'h01C));
    vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 1, 32'h024, 0, 32'h000));
    vecs.push_back(mk(0, 0, 1, 32'h100, 1, 0, 0, 32'h028, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h100, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h100, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h104, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h108, 1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h108, 1, 32'h104));
    // fill under stall, then branch and stall together
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 1, 32'h10C, 0, 32'h000));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 0, 32'h110, 1, 32'h108));
    vecs.push_back(mk(0, 1, 1, 32'h200, 0, 0, 0, 32'h110, 1, 32'h108));
    vecs.push_back(mk(0, 1, 0, 32'h0,   0, 0, 1, 32'h200, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h204, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h208, 1, 32'h200));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h208, 1, 32'h204));
    // reset with one outstanding, then a spurious response with nothing outstanding
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 32'h20C, 0, 32'h000));
    vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 0, 32'h000, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 1, 32'h000, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 1, 32'h004, 0, 32'h000));
    vecs.push_back(mk(0, 0, 0, 32'h0,   0, 0, 0, 32'h008, 1, 32'h000));

    reset = 1'b1; stall = 1'b0; beq_taken = 1'b0; branch_target = 32'h0; imem_gnt = 1'b1;
    hold = 1'b0; spur = 1'b0; rvalid1 = 1'b0; rdata1 = 32'h0; rvalid2 = 1'b0; rdata2 = 32'h0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    advance();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.stl, v.beq, v.tgt, v.hld, v.spr);
      chk($sformatf("row%0d imem_req", i), {31'b0, req1}, {31'b0, v.exp_req});
      chk($sformatf("row%0d imem_addr", i), addr1, v.exp_addr);
      chk($sformatf("row%0d instr_valid", i), {31'b0, valid1}, {31'b0, v.exp_valid});
      chk($sformatf("row%0d pc_out", i), pc1, v.exp_pc);
      chk($sformatf("row%0d instruction_out", i), instr1, v.exp_valid ? (v.exp_pc ^ KEY) : 32'h0);
      advance();
    end

    // Fresh reset of both instances; the second one wraps past the top of the address space.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap reset valid", {31'b0, valid2}, 32'd0);
    advance();
    n1 = 0; n2 = 0; e1 = 32'h0000_0000; e2 = 32'hFFFF_FFF8;
    for (int c = 0; c < 40 && (n1 < 4 || n2 < 4); c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      if (c == 0) begin
        chk("wrap first req", {31'b0, req2}, 32'd1);
        chk("wrap first addr", addr2, 32'hFFFF_FFF8);
      end
      if (valid1 && n1 < 4) begin
        chk($sformatf("seq%0d pc_out", n1), pc1, e1);
        chk($sformatf("seq%0d instruction_out", n1), instr1, e1 ^ KEY);
        e1 = e1 + 32'd4;
        n1++;
      end
      if (valid2 && n2 < 4) begin
        chk($sformatf("wrap%0d pc_out", n2), pc2, e2);
        chk($sformatf("wrap%0d instruction_out", n2), instr2, e2 ^ KEY);
        e2 = e2 + 32'd4;
        n2++;
      end
      advance();
    end
    chk("seq delivered count", n1, 4);
    chk("wrap delivered count", n2, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
